// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-memory geometry, instruction byte order and
// the program loader's state encoding.
package cpu_pkg;

  localparam int PROG_MEM_BYTES   = 256;
  localparam int PROG_AW          = 8;

  // A 16-bit instruction at address a is stored low byte first.
  localparam int LOW_BYTE_OFFSET  = 0;
  localparam int HIGH_BYTE_OFFSET = 1;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_LEN  = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_DONE = 3'd4,
    LD_ERR  = 3'd5
  } loader_state_e;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream valid/ready handshake between the download port (master) and
// the program loader (slave).
interface program_loader_if;

  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);

endinterface

// File: rtl/loader_checksum.sv
// Modulo-256 running sum of the image bytes with clear, add and compare.
// Instantiated by program_loader only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module loader_checksum
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] data,
  input  logic [7:0] cmp,
  output logic       match
);

  logic [7:0] sum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg <= '0;
    end else if (clr) begin
      sum_reg <= '0;
    end else if (add) begin
      sum_reg <= csum_add(sum_reg, data);
    end
  end

  assign match = (sum_reg == cmp);

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into program memory while holding the CPU.
// Optional trailing checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import cpu_pkg::*;
#(
  parameter int MEM_AW = PROG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  program_loader_if.slave   stream,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  loader_state_e     state_reg, state_next;
  logic [MEM_AW-1:0] addr_reg, addr_next;
  // One bit wider than the address so a full-memory image (N=0) is representable.
  logic [MEM_AW:0]   remain_reg, remain_next;
  logic              mem_we_reg, mem_we_next;
  logic [MEM_AW-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        mem_wdata_reg, mem_wdata_next;
  logic [MEM_AW:0]   len_val;
  logic              accept;
  logic              csum_clr;
  logic              csum_add_en;

  assign accept = stream.byte_valid && stream.byte_ready;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic csum_match;

  loader_checksum u_checksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (csum_clr),
    .add   (csum_add_en),
    .data  (stream.byte_in),
    .cmp   (stream.byte_in),
    .match (csum_match)
  );
`endif

  always_comb begin
    len_val = (MEM_AW+1)'(stream.byte_in);
    if (len_val == '0) begin
      len_val = {1'b1, {MEM_AW{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LD_IDLE;
      addr_reg      <= '0;
      remain_reg    <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remain_reg    <= remain_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remain_next    = remain_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    csum_clr       = 1'b0;
    csum_add_en    = 1'b0;

    case (state_reg)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_next = LD_LEN;
          addr_next  = '0;
          csum_clr   = 1'b1;
        end
      end
      LD_LEN: begin
        if (accept) begin
          remain_next = len_val;
          state_next  = LD_DATA;
        end
      end
      LD_DATA: begin
        if (accept) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = addr_reg;
          mem_wdata_next = stream.byte_in;
          addr_next      = addr_reg + 1'b1;
          remain_next    = remain_reg - 1'b1;
          csum_add_en    = 1'b1;
          if (remain_reg == (MEM_AW+1)'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_next = LD_CSUM;
`else
            state_next = LD_DONE;
`endif
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      LD_CSUM: begin
        if (accept) begin
          state_next = csum_match ? LD_DONE : LD_ERR;
        end
      end
`endif
      default: state_next = LD_IDLE;
    endcase
  end

  assign stream.byte_ready = (state_reg == LD_LEN) || (state_reg == LD_DATA) ||
                             (state_reg == LD_CSUM);
  assign cpu_hold  = stream.byte_ready || (state_reg == LD_ERR);
  assign load_done = (state_reg == LD_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign load_err  = (state_reg == LD_ERR);
`else
  assign load_err  = 1'b0;
`endif

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a byte-count reference model and
// a per-cycle output compare; handles both PROGRAM_LOADER_CHECKSUM_EN builds.
module tb_program_loader;
  import cpu_pkg::*;

  localparam int AW    = PROG_AW;
  localparam int MEM_N = PROG_MEM_BYTES;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  program_loader_if bus ();

  program_loader #(.MEM_AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stream    (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int we_count = 0;
  logic [7:0] dut_mem [MEM_N];
  logic [7:0] exp_mem [MEM_N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts bytes accepted since start (byte 0 = length,
  // bytes 1..N = image, byte N+1 = checksum) and derives outputs from that.
  bit         m_loading = 0, m_done = 0, m_err = 0, m_we = 0;
  int         m_got = 0, m_n = 0, m_waddr = 0;
  logic [7:0] m_sum = 0, m_wdata = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_done = 0; m_err = 0; m_we = 0;
      m_got = 0; m_n = 0; m_waddr = 0; m_sum = 0; m_wdata = 0;
    end else begin
      m_we = 0;
      if (!m_loading) begin
        if (start) begin
          m_loading = 1; m_done = 0; m_err = 0; m_got = 0; m_sum = 0;
        end
      end else if (bus.byte_valid) begin
        if (m_got == 0) begin
          m_n = (bus.byte_in == 0) ? MEM_N : int'(bus.byte_in);
        end else if (m_got <= m_n) begin
          m_we = 1;
          m_waddr = (m_got - 1) % MEM_N;
          m_wdata = bus.byte_in;
          exp_mem[m_waddr] = bus.byte_in;
          m_sum = m_sum + bus.byte_in;
          if (m_got == m_n && !CSUM) begin
            m_loading = 0; m_done = 1;
          end
        end else begin
          m_loading = 0;
          if (bus.byte_in == m_sum) m_done = 1;
          else m_err = 1;
        end
        m_got++;
      end
    end
  end

  always @(negedge clk) begin
    chk("byte_ready", 32'(bus.byte_ready), 32'(m_loading));
    chk("cpu_hold",   32'(cpu_hold),       32'(m_loading || m_err));
    chk("load_done",  32'(load_done),      32'(m_done));
    chk("load_err",   32'(load_err),       32'(m_err));
    chk("mem_we",     32'(mem_we),         32'(m_we));
    chk("mem_addr",   32'(mem_addr),       32'(m_waddr));
    chk("mem_wdata",  32'(mem_wdata),      32'(m_wdata));
    if (mem_we === 1'b1) begin
      dut_mem[mem_addr] = mem_wdata;
      we_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit glitch, output bit ok);
    if ($urandom_range(99) < gap_pct) begin
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      tick();
    end
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    if (glitch) start = 1'b1;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: got no accept want accept of %0h at %0t", b, $time);
    end
  endtask

  bit done_at_end, hold_at_end, we_at_end;

  task automatic run_load(input int n, input logic [7:0] data[$], input int gap_pct,
                          input bit bad_csum, input bit glitch, input string tag);
    bit ok;
    logic [7:0] sum;
    int diffs;
    sum = 0;
    we_count = 0;
    pulse_start();
    send_byte(8'(n % 256), gap_pct, 1'b0, ok);
    for (int i = 0; i < n && ok; i++) begin
      send_byte(data[i], gap_pct, glitch && (i == n / 2), ok);
      sum = sum + data[i];
    end
    if (CSUM && ok) send_byte(bad_csum ? sum + 8'd1 : sum, gap_pct, 1'b0, ok);
    done_at_end = load_done;
    hold_at_end = cpu_hold;
    we_at_end   = mem_we;
    tick();
    tick();
    diffs = 0;
    for (int a = 0; a < MEM_N; a++) if (dut_mem[a] !== exp_mem[a]) diffs++;
    chk("mem_image_diffs", 32'(diffs), 32'd0);
    chk("we_pulse_count", 32'(we_count), 32'(n));
    $display("load %s n=%0d gap=%0d done=%0b err=%0b writes=%0d", tag, n, gap_pct,
             load_done, load_err, we_count);
  endtask

  initial begin
    logic [7:0] q[$];
    bit ok;
    int n;

    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    for (int a = 0; a < MEM_N; a++) begin
      dut_mem[a] = 8'h00;
      exp_mem[a] = 8'h00;
    end

    #12;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Four-byte image; the first instruction word pins byte order.
    q = {8'h11, 8'h22, 8'h33, 8'h44};
    run_load(4, q, 0, 1'b0, 1'b0, "basic4");
    chk("basic_addr0", 32'(dut_mem[0]), 32'h11);
    chk("basic_addr3", 32'(dut_mem[3]), 32'h44);
    chk("basic_insn0", 32'({dut_mem[HIGH_BYTE_OFFSET], dut_mem[LOW_BYTE_OFFSET]}), 32'h2211);
    chk("basic_done_after_last", 32'(done_at_end), 32'd1);
    chk("basic_hold_after_last", 32'(hold_at_end), 32'd0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    chk("basic_last_we", 32'(we_at_end), 32'd1);
`endif

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    q = {8'hF0, 8'h20};
    run_load(2, q, 0, 1'b0, 1'b0, "csum_ok");
    chk("csum_ok_done", 32'(load_done), 32'd1);
    run_load(2, q, 0, 1'b1, 1'b0, "csum_bad");
    chk("csum_bad_err", 32'(load_err), 32'd1);
    chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
    chk("csum_bad_done", 32'(load_done), 32'd0);
`endif

    // Full-memory image (length byte 0).
    q = {};
    for (int i = 0; i < MEM_N; i++) q.push_back(8'(i));
    run_load(MEM_N, q, 0, 1'b0, 1'b0, "full256");
    chk("full_addr255", 32'(dut_mem[255]), 32'hFF);
    chk("full_addr0", 32'(dut_mem[0]), 32'h00);
    chk("full_we_256", 32'(we_count), 32'd256);

    // Valid gaps before every byte.
    q = {8'hA1, 8'hB2, 8'hC3};
    run_load(3, q, 100, 1'b0, 1'b0, "gaps3");
    chk("gaps_addr2", 32'(dut_mem[2]), 32'hC3);

    // Reset after two of five data bytes.
    pulse_start();
    send_byte(8'd5, 0, 1'b0, ok);
    send_byte(8'hA5, 0, 1'b0, ok);
    send_byte(8'h5A, 0, 1'b0, ok);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("midrst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    tick();
    #1 rst_n = 1'b1;
    tick();
    chk("midrst_keep0", 32'(dut_mem[0]), 32'hA5);
    chk("midrst_keep1", 32'(dut_mem[1]), 32'h5A);
    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(5, q, 0, 1'b0, 1'b0, "after_rst");
    chk("after_rst_addr4", 32'(dut_mem[4]), 32'h05);

    // start pulsed in the middle of the data phase.
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    run_load(8, q, 30, 1'b0, 1'b1, "start_glitch");

    for (int t = 0; t < 15; t++) begin
      n = $urandom_range(1, 40);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_load(n, q, $urandom_range(0, 60), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
